// File: rtl/yarp_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a DEPTH-entry output queue.
// Optional illegal-encoding detection is enabled by defining YARP_DECODE_ILLEGAL_EN.
module yarp_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            r_type_o,
    output logic            i_type_o,
    output logic            s_type_o,
    output logic            b_type_o,
    output logic            u_type_o,
    output logic            j_type_o,
    output logic [31:0]     imm_o,
    output logic            illegal_o,
    output logic [31:0]     instr_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Raw instruction is kept per entry; register fields are sliced from the head.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      types;   // {r, i, s, b, u, j}
        logic [31:0]     imm;
`ifdef YARP_DECODE_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_instr_count;

    entry_t             w_entry;
    entry_t             w_head;
    logic [6:0]         w_op;
    logic [5:0]         w_types;
    logic [31:0]        w_imm;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_op = instr_i[6:0];

    always_comb begin
        w_types = 6'b000000;
        w_imm   = 32'h0;
        case (w_op)
            7'h33: w_types = 6'b100000;
            7'h13, 7'h03, 7'h67: begin
                w_types = 6'b010000;
                w_imm   = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            7'h23: begin
                w_types = 6'b001000;
                w_imm   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            7'h63: begin
                w_types = 6'b000100;
                w_imm   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                w_types = 6'b000010;
                w_imm   = {instr_i[31:12], 12'h000};
            end
            7'h6F: begin
                w_types = 6'b000001;
                w_imm   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef YARP_DECODE_ILLEGAL_EN
    logic w_illegal;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    assign w_f3 = instr_i[14:12];
    assign w_f7 = instr_i[31:25];

    always_comb begin
        w_illegal = (w_types == 6'b000000) || (instr_i[1:0] != 2'b11);
        if (w_types[5]) begin
            if ((w_f7 != 7'h00) && (w_f7 != 7'h20))
                w_illegal = 1'b1;
            else if ((w_f7 == 7'h20) && (w_f3 != 3'b000) && (w_f3 != 3'b101))
                w_illegal = 1'b1;
        end
        if (w_types[2] && ((w_f3 == 3'b010) || (w_f3 == 3'b011)))
            w_illegal = 1'b1;
    end
`endif

    always_comb begin
        w_entry       = '0;
        w_entry.pc    = pc_i;
        w_entry.instr = instr_i[31:0];
        w_entry.types = w_types;
        w_entry.imm   = w_imm;
`ifdef YARP_DECODE_ILLEGAL_EN
        w_entry.illegal = w_illegal;
`endif
    end

    assign instr_ready_o = (r_count < CNT_W'(DEPTH));
    assign dec_valid_o   = (r_count != '0);
    assign w_push        = instr_valid_i & instr_ready_o & ~flush_i;
    assign w_pop         = dec_valid_o & dec_ready_i & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_instr_count <= 32'h0;
        else if (w_push) r_instr_count <= r_instr_count + 32'h1;
    end

    // Entry storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_entry;
    end

    assign w_head = dec_valid_o ? r_mem[r_rptr] : '0;

    assign pc_o          = w_head.pc;
    assign rs1_o         = w_head.instr[19:15];
    assign rs2_o         = w_head.instr[24:20];
    assign rd_o          = w_head.instr[11:7];
    assign op_o          = w_head.instr[6:0];
    assign funct3_o      = w_head.instr[14:12];
    assign funct7_o      = w_head.instr[31:25];
    assign {r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o} = w_head.types;
    assign imm_o         = w_head.imm;
    assign instr_count_o = r_instr_count;
`ifdef YARP_DECODE_ILLEGAL_EN
    assign illegal_o     = w_head.illegal;
`else
    assign illegal_o     = 1'b0;
`endif

endmodule

// File: tb/tb_yarp_decode_stage.sv
// Directed bench for yarp_decode_stage: decode vector table plus backpressure, wrap, flush and reset sequences.
module tb_yarp_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [6:0]  op_o, funct7_o;
    logic [2:0]  funct3_o;
    logic        r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o;
    logic [31:0] imm_o;
    logic        illegal_o;
    logic [31:0] instr_count_o;

`ifdef YARP_DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    yarp_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .op_o(op_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
        .r_type_o(r_type_o), .i_type_o(i_type_o), .s_type_o(s_type_o),
        .b_type_o(b_type_o), .u_type_o(u_type_o), .j_type_o(j_type_o),
        .imm_o(imm_o), .illegal_o(illegal_o), .instr_count_o(instr_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  types;  // {r, i, s, b, u, j}
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_cnt = 0;
    vec_t vecs[13];

    function automatic vec_t mk(logic [31:0] instr, logic [5:0] types, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic [6:0] op,
                                logic [2:0] f3, logic [6:0] f7, logic [31:0] imm, logic ill);
        vec_t v;
        v.instr = instr; v.types = types; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.op = op; v.f3 = f3; v.f7 = f7; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'b0, dec_valid_o}, 32'd0);
        chk({tag, "_pc"},    pc_o, 32'd0);
        chk({tag, "_imm"},   imm_o, 32'd0);
        chk({tag, "_fields"}, {12'b0, rd_o, op_o, funct3_o, r_type_o, i_type_o,
                               s_type_o, b_type_o, u_type_o, j_type_o}, 32'd0);
        chk({tag, "_ready"}, {31'b0, instr_ready_o}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        int pushes;
        bit will_push, will_pop;

        vecs[0]  = mk(32'h00500093, 6'b010000, 5'd1,  5'd0, 5'd5,  7'h13, 3'd0, 7'h00, 32'h00000005, 1'b0);
        vecs[1]  = mk(32'h0020A223, 6'b001000, 5'd4,  5'd1, 5'd2,  7'h23, 3'd2, 7'h00, 32'h00000004, 1'b0);
        vecs[2]  = mk(32'hFE000EE3, 6'b000100, 5'h1D, 5'd0, 5'd0,  7'h63, 3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0);
        vecs[3]  = mk(32'h008000EF, 6'b000001, 5'd1,  5'd0, 5'd8,  7'h6F, 3'd0, 7'h00, 32'h00000008, 1'b0);
        vecs[4]  = mk(32'h123452B7, 6'b000010, 5'd5,  5'd8, 5'd3,  7'h37, 3'd5, 7'h09, 32'h12345000, 1'b0);
        vecs[5]  = mk(32'h002081B3, 6'b100000, 5'd3,  5'd1, 5'd2,  7'h33, 3'd0, 7'h00, 32'h00000000, 1'b0);
        vecs[6]  = mk(32'h402081B3, 6'b100000, 5'd3,  5'd1, 5'd2,  7'h33, 3'd0, 7'h20, 32'h00000000, 1'b0);
        vecs[7]  = mk(32'h402091B3, 6'b100000, 5'd3,  5'd1, 5'd2,  7'h33, 3'd1, 7'h20, 32'h00000000, 1'b1);
        vecs[8]  = mk(32'h0000007F, 6'b000000, 5'd0,  5'd0, 5'd0,  7'h7F, 3'd0, 7'h00, 32'h00000000, 1'b1);
        vecs[9]  = mk(32'h00002063, 6'b000100, 5'd0,  5'd0, 5'd0,  7'h63, 3'd2, 7'h00, 32'h00000000, 1'b1);
        vecs[10] = mk(32'h00001097, 6'b000010, 5'd1,  5'd0, 5'd0,  7'h17, 3'd1, 7'h00, 32'h00001000, 1'b0);
        vecs[11] = mk(32'hFF812283, 6'b010000, 5'd5,  5'd2, 5'h18, 7'h03, 3'd2, 7'h7F, 32'hFFFFFFF8, 1'b0);
        vecs[12] = mk(32'h00500091, 6'b000000, 5'd1,  5'd0, 5'd5,  7'h11, 3'd0, 7'h00, 32'h00000000, 1'b1);

        reset = 1'b1; instr_valid_i = 1'b0; instr_i = '0; pc_i = '0;
        flush_i = 1'b0; dec_ready_i = 1'b0;
        step(); step();
        chk_empty("reset");
        chk("reset_count", instr_count_o, 32'd0);
        #2 reset = 1'b0;
        step();

        // Decode table streamed back-to-back: each entry is pushed and popped in consecutive cycles.
        dec_ready_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            instr_valid_i = 1'b1;
            instr_i = vecs[i].instr;
            pc_i = 32'h1000 + 32'(4 * i);
            step();
            exp_cnt++;
            chk($sformatf("v%0d_valid", i), {31'b0, dec_valid_o}, 32'd1);
            chk($sformatf("v%0d_types", i),
                {26'b0, r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o}, {26'b0, vecs[i].types});
            chk($sformatf("v%0d_regs", i), {17'b0, rd_o, rs1_o, rs2_o},
                {17'b0, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
            chk($sformatf("v%0d_ops", i), {15'b0, op_o, funct3_o, funct7_o},
                {15'b0, vecs[i].op, vecs[i].f3, vecs[i].f7});
            chk($sformatf("v%0d_imm", i), imm_o, vecs[i].imm);
            chk($sformatf("v%0d_ill", i), {31'b0, illegal_o}, {31'b0, vecs[i].ill & ILL_EN});
            chk($sformatf("v%0d_pc", i), pc_o, 32'h1000 + 32'(4 * i));
            chk($sformatf("v%0d_count", i), instr_count_o, exp_cnt);
        end
        instr_valid_i = 1'b0;
        step();
        chk_empty("drain");

        // Backpressure: third instruction waits until one entry is popped.
        dec_ready_i = 1'b0; instr_valid_i = 1'b1; instr_i = 32'h00100093;
        pc_i = 32'h3000; step(); exp_cnt++;
        chk("bp_ready1", {31'b0, instr_ready_o}, 32'd1);
        pc_i = 32'h3004; step(); exp_cnt++;
        chk("bp_full_ready", {31'b0, instr_ready_o}, 32'd0);
        chk("bp_head0", pc_o, 32'h3000);
        pc_i = 32'h3008; step();
        chk("bp_blocked_count", instr_count_o, exp_cnt);
        chk("bp_head_stable", pc_o, 32'h3000);
        dec_ready_i = 1'b1; step();
        chk("bp_pop_head", pc_o, 32'h3004);
        chk("bp_ready_back", {31'b0, instr_ready_o}, 32'd1);
        chk("bp_count_after_pop", instr_count_o, exp_cnt);
        step(); exp_cnt++;
        chk("bp_third_head", pc_o, 32'h3008);
        chk("bp_third_count", instr_count_o, exp_cnt);
        instr_valid_i = 1'b0; step();
        chk("bp_empty", {31'b0, dec_valid_o}, 32'd0);

        // Wrap-around: 10 pushes with irregular dec_ready against a queue model.
        pushes = 0;
        q.delete();
        for (int cyc = 0; cyc < 60 && pushes < 10; cyc++) begin
            instr_valid_i = 1'b1;
            instr_i = 32'h00000013;
            pc_i = 32'h2000 + 32'(4 * pushes);
            dec_ready_i = (cyc % 3) != 1;
            #1;
            will_push = q.size() < 2;
            will_pop  = (q.size() != 0) && dec_ready_i;
            chk($sformatf("wrap%0d_ready", cyc), {31'b0, instr_ready_o}, {31'b0, will_push});
            step();
            if (will_pop) void'(q.pop_front());
            if (will_push) begin
                q.push_back(pc_i);
                pushes++;
                exp_cnt++;
            end
            chk($sformatf("wrap%0d_valid", cyc), {31'b0, dec_valid_o}, {31'b0, q.size() != 0});
            if (q.size() != 0) chk($sformatf("wrap%0d_pc", cyc), pc_o, q[0]);
        end
        chk("wrap_pushes", pushes, 10);
        chk("wrap_count", instr_count_o, exp_cnt);
        instr_valid_i = 1'b0; dec_ready_i = 1'b1;
        step(); step();
        chk("wrap_drained", {31'b0, dec_valid_o}, 32'd0);

        // Flush with a full queue and a same-cycle offered instruction.
        dec_ready_i = 1'b0; instr_valid_i = 1'b1; instr_i = 32'h00700113;
        pc_i = 32'h4000; step(); exp_cnt++;
        pc_i = 32'h4004; step(); exp_cnt++;
        chk("fl_full", {31'b0, instr_ready_o}, 32'd0);
        flush_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h4008; step();
        chk_empty("flush");
        chk("flush_count", instr_count_o, exp_cnt);
        flush_i = 1'b0; instr_valid_i = 1'b0; step();
        chk("flush_dropped", {31'b0, dec_valid_o}, 32'd0);

        // Asynchronous reset with two entries queued.
        instr_valid_i = 1'b1; instr_i = 32'h00100093;
        pc_i = 32'h5000; step();
        pc_i = 32'h5004; step();
        chk("ar_pre_valid", {31'b0, dec_valid_o}, 32'd1);
        instr_valid_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, dec_valid_o}, 32'd0);
        chk("ar_count", instr_count_o, 32'd0);
        chk("ar_pc", pc_o, 32'd0);
        chk("ar_ready", {31'b0, instr_ready_o}, 32'd1);
        #3 reset = 1'b0;
        step();
        chk("ar_after", {31'b0, dec_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/yarp_decode_stage.md
# yarp_decode_stage

Registered, parametrised RV32I decode stage sitting between fetch and execute in the yarp core. Accepts fetched instructions over a valid/ready handshake, decodes register indices, opcode fields, instruction-type flags and sign-extended immediates, and holds the decoded results in a DEPTH-entry output queue so fetch is decoupled from execute stalls. Supports pipeline flush, counts decoded instructions, and can optionally detect illegal encodings.

## Interface
- XLEN, 32, instruction and PC width; only 32 is supported.
- DEPTH, 2, output queue entries; legal range 2..16, any integer.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid_i  in  1  fetch presents an instruction.
- instr_ready_o  out  1  stage can accept; equals (count < DEPTH); no combinational path from dec_ready_i.
- instr_i  in  XLEN  raw instruction.
- pc_i  in  XLEN  PC of instr_i.
- flush_i  in  1  discard all queued entries and any same-cycle input.
- dec_valid_o  out  1  head entry is valid.
- dec_ready_i  in  1  execute consumes the head entry.
- pc_o  out  XLEN  PC of head entry.
- rs1_o, rs2_o, rd_o  out  5 each  instr[19:15], [24:20], [11:7].
- op_o  out  7  instr[6:0].
- funct3_o  out  3  instr[14:12].
- funct7_o  out  7  instr[31:25].
- r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o  out  1 each  one-hot type flags; all 0 for an unknown opcode.
- imm_o  out  32  decoded immediate.
- illegal_o  out  1  head entry is an illegal encoding.
- instr_count_o  out  32  count of accepted instructions.

## Operation
- Opcode map: 0x33 R; 0x13, 0x03, 0x67 I; 0x23 S; 0x63 B; 0x37, 0x17 U; 0x6F J; all others unknown.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({[31:25], [11:7]}).
  - B: sext({[31], [7], [30:25], [11:8], 0}).
  - U: {[31:12], 12'h0}.
  - J: sext({[31], [19:12], [20], [30:21], 0}).
  - R and unknown: 0.
- Decode is combinational on instr_i. The result and pc_i are written into the queue on push = instr_valid_i & instr_ready_o & ~flush_i.
- Pop = dec_valid_o & dec_ready_i & ~flush_i.
- Queue: circular buffer with write pointer, read pointer and count (0..DEPTH). Pointers wrap from DEPTH-1 to 0. Push and pop in the same cycle leave count unchanged.
- Outputs come from the head entry. When count == 0, dec_valid_o = 0 and every data output is 0.
- flush_i has priority over push and pop. Next cycle: count = 0, pointers = 0, and the input offered on the flush cycle is dropped.
- instr_count_o increments by 1 on every push and wraps 0xFFFFFFFF -> 0. Flush does not clear it.

## Timing
- Reset values: count, pointers and instr_count_o = 0; dec_valid_o = 0; all data outputs = 0; instr_ready_o = 1.
- Latency: an instruction pushed at edge N appears on dec_valid_o after edge N when the queue was empty (1 cycle).
- Throughput: 1 instruction/cycle when dec_ready_i is held high.
- Full (count == DEPTH): instr_ready_o = 0. A pop in that cycle lowers count, and instr_ready_o rises the following cycle.
- dec_valid_o stays asserted and the head data stays stable until popped or flushed.
- Reset asserted mid-operation: the queue empties immediately (asynchronously), and in-flight entries are lost.

## Configuration
- YARP_DECODE_ILLEGAL_EN defined:
  - illegal_o = 1 for any unknown opcode, or instr[1:0] != 2'b11.
  - illegal_o = 1 for R-type with funct7 not in {0x00, 0x20}, or with funct7 = 0x20 and funct3 not in {000, 101}.
  - illegal_o = 1 for B-type with funct3 in {010, 011}.
  - The flag is stored per entry.
- YARP_DECODE_ILLEGAL_EN undefined: illegal_o tied to 0 and no storage is allocated for it. All other behaviour is identical.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) with dec_ready_i = 1 -> next cycle dec_valid_o = 1, i_type_o = 1, rd_o = 1, rs1_o = 0, imm_o = 5, instr_count_o = 1.
- Stream 0x0020A223, 0xFE000EE3, 0x008000EF, 0x123452B7 back-to-back -> in order:
  - s_type_o, imm_o = 4.
  - b_type_o, imm_o = 0xFFFFFFFC.
  - j_type_o, rd_o = 1, imm_o = 8.
  - u_type_o, imm_o = 0x12345000.
- dec_ready_i = 0, push 3 instructions with DEPTH = 2 -> instr_ready_o = 0 after 2 accepted. Raise dec_ready_i -> the 3rd is accepted after 1 pop, and order is preserved. Wrap-around is exercised over 10 pushes.
- Fill the queue with 2 entries, assert flush_i together with instr_valid_i -> next cycle dec_valid_o = 0, outputs 0, the flush-cycle input is discarded, and instr_count_o is unchanged by the dropped input.
- Push 0x0000007F with YARP_DECODE_ILLEGAL_EN defined -> illegal_o = 1 and all type flags 0. Without the macro -> illegal_o = 0.
- Assert reset asynchronously mid-stream with 2 entries queued -> dec_valid_o = 0 and instr_count_o = 0 before the next clock edge.
